// File: rtl/mem_result_checker.sv
// Post-run RAM checker: waits for a cycle budget or CPU halt, then reads back
// NUM_CHECKS (address, expected) pairs and reports pass/fail statistics.
module mem_result_checker #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 10,
  parameter int NUM_CHECKS    = 4,
  parameter int WAIT_CYCLES   = 10000
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              i_start,
  input  logic                                              i_halt,
  input  logic [NUM_CHECKS*ADDRESS_WIDTH-1:0]               i_exp_addr,
  input  logic [NUM_CHECKS*DATA_WIDTH-1:0]                  i_exp_data,
  output logic                                              o_own_bus,
  output logic [ADDRESS_WIDTH-1:0]                          o_rd_addr,
  input  logic [DATA_WIDTH-1:0]                             i_rd_data,
  output logic                                              o_busy,
  output logic                                              o_done,
  output logic                                              o_pass,
  output logic [$clog2(NUM_CHECKS+1)-1:0]                   o_fail_count,
  output logic [((NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1)-1:0] o_first_fail
);

  localparam int FCW = $clog2(NUM_CHECKS + 1);
  localparam int IW  = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
  localparam int CW  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_CMP,
    S_DONE
  } state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [IW-1:0]        idx, idx_n;
  logic [FCW-1:0]       fails, fails_n;
  logic [IW-1:0]        first, first_n;
  logic [ADDRESS_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0]    cur_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
      fails <= '0;
      first <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      fails <= fails_n;
      first <= first_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    fails_n  = fails;
    first_n  = first;
    cur_addr = i_exp_addr[idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    cur_data = i_exp_data[idx*DATA_WIDTH +: DATA_WIDTH];
    case (state)
      // DONE shares the IDLE start path so a restart clears previous results
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_n = S_WAIT;
          cnt_n   = CW'(WAIT_CYCLES);
          idx_n   = '0;
          fails_n = '0;
          first_n = '0;
        end
      end
      S_WAIT: begin
        if (cnt == '0 || i_halt) begin
          state_n = S_READ;
          idx_n   = '0;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      S_READ: state_n = S_CMP;
      S_CMP: begin
        if (i_rd_data != cur_data) begin
          fails_n = fails + FCW'(1);
          if (fails == '0) first_n = idx;
        end
        if (idx == IW'(NUM_CHECKS - 1)) begin
          state_n = S_DONE;
        end else begin
          idx_n   = idx + IW'(1);
          state_n = S_READ;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign o_own_bus    = (state == S_READ) || (state == S_CMP);
  assign o_rd_addr    = o_own_bus ? cur_addr : '0;
  assign o_busy       = (state == S_WAIT) || o_own_bus;
  assign o_done       = (state == S_DONE);
  assign o_pass       = o_done && (fails == '0);
  assign o_fail_count = fails;
  assign o_first_fail = first;

endmodule

// File: tb/tb_mem_result_checker.sv
// Scoreboard bench: three checker instances (N=1/W=20, N=4/W=10000, N=2/W=0)
// sharing one RAM model with 1-cycle read latency.
module tb_mem_result_checker;
  localparam int AW = 6;
  localparam int DW = 10;
  localparam int NC[3] = '{1, 4, 2};
  localparam int WC[3] = '{20, 10000, 0};

  typedef struct {
    int lat;
    int pass;
    int fails;
    int first;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  logic [DW-1:0] mem[64];
  logic [AW-1:0] ea[3][4];
  logic [DW-1:0] ed[3][4];
  logic start[3];
  logic halt[3];

  logic [1*AW-1:0] a_eaddr;
  logic [4*AW-1:0] b_eaddr;
  logic [2*AW-1:0] c_eaddr;
  logic [1*DW-1:0] a_edata;
  logic [4*DW-1:0] b_edata;
  logic [2*DW-1:0] c_edata;
  logic a_own, b_own, c_own, a_busy, b_busy, c_busy;
  logic a_done, b_done, c_done, a_pass, b_pass, c_pass;
  logic [AW-1:0] a_addr, b_addr, c_addr;
  logic [DW-1:0] a_rd, b_rd, c_rd;
  logic [0:0] a_fc;
  logic [2:0] b_fc;
  logic [1:0] c_fc;
  logic [0:0] a_ff;
  logic [1:0] b_ff;
  logic [0:0] c_ff;

  always_comb begin
    a_eaddr = ea[0][0];
    a_edata = ed[0][0];
    b_eaddr = {ea[1][3], ea[1][2], ea[1][1], ea[1][0]};
    b_edata = {ed[1][3], ed[1][2], ed[1][1], ed[1][0]};
    c_eaddr = {ea[2][1], ea[2][0]};
    c_edata = {ed[2][1], ed[2][0]};
  end

  always @(posedge clk) begin
    a_rd <= mem[a_addr];
    b_rd <= mem[b_addr];
    c_rd <= mem[c_addr];
  end

  mem_result_checker #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CHECKS(1), .WAIT_CYCLES(20)) dut_a (
    .clk(clk), .rst(rst), .i_start(start[0]), .i_halt(halt[0]),
    .i_exp_addr(a_eaddr), .i_exp_data(a_edata), .o_own_bus(a_own), .o_rd_addr(a_addr),
    .i_rd_data(a_rd), .o_busy(a_busy), .o_done(a_done), .o_pass(a_pass),
    .o_fail_count(a_fc), .o_first_fail(a_ff));

  mem_result_checker #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CHECKS(4), .WAIT_CYCLES(10000)) dut_b (
    .clk(clk), .rst(rst), .i_start(start[1]), .i_halt(halt[1]),
    .i_exp_addr(b_eaddr), .i_exp_data(b_edata), .o_own_bus(b_own), .o_rd_addr(b_addr),
    .i_rd_data(b_rd), .o_busy(b_busy), .o_done(b_done), .o_pass(b_pass),
    .o_fail_count(b_fc), .o_first_fail(b_ff));

  mem_result_checker #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CHECKS(2), .WAIT_CYCLES(0)) dut_c (
    .clk(clk), .rst(rst), .i_start(start[2]), .i_halt(halt[2]),
    .i_exp_addr(c_eaddr), .i_exp_data(c_edata), .o_own_bus(c_own), .o_rd_addr(c_addr),
    .i_rd_data(c_rd), .o_busy(c_busy), .o_done(c_done), .o_pass(c_pass),
    .o_fail_count(c_fc), .o_first_fail(c_ff));

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic samp(input int d, output int done, output int busy, output int own,
                      output int addr, output int pass, output int fc, output int ff);
    case (d)
      0: begin done = a_done; busy = a_busy; own = a_own; addr = a_addr; pass = a_pass; fc = a_fc; ff = a_ff; end
      1: begin done = b_done; busy = b_busy; own = b_own; addr = b_addr; pass = b_pass; fc = b_fc; ff = b_ff; end
      default: begin done = c_done; busy = c_busy; own = c_own; addr = c_addr; pass = c_pass; fc = c_fc; ff = c_ff; end
    endcase
  endtask

  task automatic chk_zero(input int d, input string tag);
    int done, busy, own, addr, pass, fc, ff;
    samp(d, done, busy, own, addr, pass, fc, ff);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_own"}, own, 0);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_fails"}, fc, 0);
    chk({tag, "_first"}, ff, 0);
  endtask

  // Reference model: expected outcome from the bench's own RAM image.
  task automatic push_expect(input int d, input int halt_at);
    exp_t e;
    int fc = 0;
    int ff = 0;
    for (int k = 0; k < NC[d]; k++) begin
      if (mem[ea[d][k]] != ed[d][k]) begin
        if (fc == 0) ff = k;
        fc++;
      end
    end
    e.lat   = (halt_at > 0) ? halt_at + 1 + 2 * NC[d] : WC[d] + 2 + 2 * NC[d];
    e.pass  = (fc == 0) ? 1 : 0;
    e.fails = fc;
    e.first = ff;
    sb.push_back(e);
  endtask

  task automatic run(input int d, input int halt_at, input int extra_at, input string tag);
    exp_t e;
    int cyc = 0, own_cnt = 0, first_own = -1, addr_bad = 0;
    int done = 0, busy, own, addr, pass, fc, ff;
    push_expect(d, halt_at);
    @(negedge clk);
    start[d] = 1'b1;
    while (done == 0 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      start[d] = (cyc == extra_at);
      halt[d]  = (halt_at > 0 && cyc >= halt_at);
      samp(d, done, busy, own, addr, pass, fc, ff);
      if (cyc == 1) begin
        chk({tag, "_busy_start"}, busy, 1);
        chk({tag, "_cleared"}, fc, 0);
      end
      if (own != 0) begin
        own_cnt++;
        if (first_own < 0) first_own = cyc;
      end else if (addr != 0) begin
        addr_bad++;
      end
    end
    start[d] = 1'b0;
    halt[d]  = 1'b0;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_latency"}, cyc, e.lat);
      chk({tag, "_pass"}, pass, e.pass);
      chk({tag, "_fails"}, fc, e.fails);
      chk({tag, "_first"}, ff, e.first);
      chk({tag, "_own_cycles"}, own_cnt, 2 * NC[d]);
      chk({tag, "_own_first"}, first_own, e.lat - 2 * NC[d]);
      chk({tag, "_busy_done"}, busy, 0);
      chk({tag, "_addr_idle"}, addr_bad, 0);
    end
  endtask

  initial begin
    int done, busy, own, addr, pass, fc, ff;
    for (int i = 0; i < 64; i++) mem[i] = DW'(i * 3 + 1);
    for (int d = 0; d < 3; d++) begin
      start[d] = 1'b0;
      halt[d]  = 1'b0;
      for (int k = 0; k < 4; k++) begin
        ea[d][k] = '0;
        ed[d][k] = mem[0];
      end
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero(0, "rst_a");
    chk_zero(1, "rst_b");
    chk_zero(2, "rst_c");
    rst = 1'b0;

    // Single check, full budget, match
    mem[52] = 15;
    ea[0][0] = 52; ed[0][0] = 15;
    run(0, 0, 0, "a_match");
    // Start pulse during WAIT must not change latency; mismatch on entry 0
    ed[0][0] = 14;
    run(0, 0, 5, "a_busy_start");

    // One mismatch at entry 2, early halt then full budget
    mem[52] = 50;
    ea[1][0] = 10; ea[1][1] = 20; ea[1][2] = 52; ea[1][3] = 30;
    ed[1][0] = mem[10]; ed[1][1] = mem[20]; ed[1][2] = 49; ed[1][3] = mem[30];
    run(1, 30, 0, "b_halt");
    run(1, 0, 0, "b_full");
    // Entries 1 and 3 mismatch, duplicate address at entry 0; restart from DONE
    ea[1][0] = 52; ed[1][0] = 50; ed[1][2] = 50;
    ed[1][1] = mem[20] + 10'd1; ed[1][3] = mem[30] ^ 10'h200;
    run(1, 4, 0, "b_two");
    run(1, 4, 0, "b_rerun");

    // Zero wait budget, two checks
    ea[2][0] = 52; ed[2][0] = 50; ea[2][1] = 7; ed[2][1] = mem[7];
    run(2, 0, 0, "c_zero_wait");

    // Reset during CMP of entry 2: halt at 1 -> READ0@2 .. CMP2@7
    @(negedge clk);
    start[1] = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      start[1] = 1'b0;
      halt[1] = (c >= 1);
    end
    samp(1, done, busy, own, addr, pass, fc, ff);
    chk("b_cmp2_own", own, 1);
    chk("b_cmp2_addr", addr, int'(ea[1][2]));
    rst = 1'b1;
    halt[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk_zero(1, "b_midrst");
    run(1, 3, 0, "b_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
